// File: rtl/mux_4x1_if.sv
// Signal bundle for one 4:1 selector slice: four data inputs, select and load
// enable toward the selector; combinational, registered and decode results back.
interface mux_4x1_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [1:0]       sel;
    logic             en;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic [3:0]       sel_onehot;
    logic             out_chg;

    modport master (
        output in0, in1, in2, in3, sel, en,
        input  out, out_q, sel_onehot, out_chg
    );

    modport slave (
        input  in0, in1, in2, in3, sel, en,
        output out, out_q, sel_onehot, out_chg
    );
endinterface

// File: rtl/mux_4x1.sv
// 4:1 selector slice: zero-latency AND-OR select, one-hot select decode, and an
// enabled registered copy that flags whether the last load changed its value.
module mux_4x1 #(
    parameter int WIDTH = 1
) (
    input logic       clk,
    input logic       rst,
    mux_4x1_if.slave  bus
);
    logic [3:0]       sel_dec;
    logic [WIDTH-1:0] out_sel;
    logic [WIDTH-1:0] out_q_reg;
    logic [WIDTH-1:0] out_q_next;
    logic             out_chg_reg;
    logic             out_chg_next;

    // Decode built from plain gates so an X on sel propagates to every consumer.
    assign sel_dec[0] = ~bus.sel[1] & ~bus.sel[0];
    assign sel_dec[1] = ~bus.sel[1] &  bus.sel[0];
    assign sel_dec[2] =  bus.sel[1] & ~bus.sel[0];
    assign sel_dec[3] =  bus.sel[1] &  bus.sel[0];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign out_sel[gi] = (sel_dec[0] & bus.in0[gi])
                               | (sel_dec[1] & bus.in1[gi])
                               | (sel_dec[2] & bus.in2[gi])
                               | (sel_dec[3] & bus.in3[gi]);
        end
    endgenerate

    always_comb begin
        out_q_next   = out_q_reg;
        out_chg_next = 1'b0;
        if (bus.en) begin
            out_q_next   = out_sel;
            out_chg_next = (out_sel != out_q_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q_reg   <= '0;
            out_chg_reg <= 1'b0;
        end else begin
            out_q_reg   <= out_q_next;
            out_chg_reg <= out_chg_next;
        end
    end

    assign bus.out        = out_sel;
    assign bus.sel_onehot = sel_dec;
    assign bus.out_q      = out_q_reg;
    assign bus.out_chg    = out_chg_reg;
endmodule

// File: tb/tb_mux_4x1.sv
// Directed bench for mux_4x1: single-bit slice, a 7-slice map selector and a
// 4-bit instance, each checked against hand-computed values.
module tb_mux_4x1;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // single-bit instance for comb and register tests
    mux_4x1_if #(.WIDTH(1)) b1 ();
    mux_4x1 #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .bus(b1));

    // 4-bit instance
    mux_4x1_if #(.WIDTH(4)) b4 ();
    mux_4x1 #(.WIDTH(4)) u_w4 (.clk(clk), .rst(rst), .bus(b4));

    // seven slices forming the map selector
    logic [6:0] map0 = 7'b1000001;
    logic [6:0] map1 = 7'b1100011;
    logic [6:0] map2 = 7'b1110111;
    logic [6:0] map3 = 7'b1111001;
    logic [1:0] msel = 2'b00;
    logic [6:0] map_out;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_slice
            mux_4x1_if #(.WIDTH(1)) sif ();
            mux_4x1 #(.WIDTH(1)) u_slice (.clk(clk), .rst(rst), .bus(sif));
            assign sif.in0 = map0[gi];
            assign sif.in1 = map1[gi];
            assign sif.in2 = map2[gi];
            assign sif.in3 = map3[gi];
            assign sif.sel = msel;
            assign sif.en  = 1'b0;
            assign map_out[gi] = sif.out;
        end
    endgenerate

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (b1.out_q !== 1'b0) begin
            bad++; $display("FAIL reset_w1_out_q got=%b want=0", b1.out_q);
        end
        total++;
        if (b1.out_chg !== 1'b0) begin
            bad++; $display("FAIL reset_w1_out_chg got=%b want=0", b1.out_chg);
        end
        total++;
        if (b4.out_q !== 4'h0) begin
            bad++; $display("FAIL reset_w4_out_q got=%h want=0", b4.out_q);
        end
        total++;
        if (b4.out_chg !== 1'b0) begin
            bad++; $display("FAIL reset_w4_out_chg got=%b want=0", b4.out_chg);
        end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_comb_sweep();
        logic       exp_out [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] exp_oh  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        b1.in0 = 1'b1; b1.in1 = 1'b0; b1.in2 = 1'b1; b1.in3 = 1'b0;
        for (int s = 0; s < 4; s++) begin
            b1.sel = 2'(s);
            #10;
            total++;
            if (b1.out !== exp_out[s]) begin
                bad++; $display("FAIL comb_out sel=%0d got=%b want=%b", s, b1.out, exp_out[s]);
            end
            total++;
            if (b1.sel_onehot !== exp_oh[s]) begin
                bad++; $display("FAIL comb_onehot sel=%0d got=%b want=%b", s, b1.sel_onehot, exp_oh[s]);
            end
            $display("comb sel=%0d out=%b onehot=%b", s, b1.out, b1.sel_onehot);
        end
    endtask

    task automatic test_map_slice();
        logic [6:0] exp_map [4] = '{7'b1000001, 7'b1100011, 7'b1110111, 7'b1111001};
        for (int s = 0; s < 4; s++) begin
            msel = 2'(s);
            #1;
            total++;
            if (map_out !== exp_map[s]) begin
                bad++; $display("FAIL map_slice sel=%0d got=%b want=%b", s, map_out, exp_map[s]);
            end
            $display("map sel=%0d out=%b", s, map_out);
        end
    endtask

    task automatic check_reg(input string name, input logic q, input logic chg);
        total++;
        if (b1.out_q !== q) begin
            bad++; $display("FAIL %s_out_q got=%b want=%b", name, b1.out_q, q);
        end
        total++;
        if (b1.out_chg !== chg) begin
            bad++; $display("FAIL %s_out_chg got=%b want=%b", name, b1.out_chg, chg);
        end
        $display("%s out_q=%b out_chg=%b", name, b1.out_q, b1.out_chg);
    endtask

    task automatic test_register();
        @(negedge clk);
        rst = 1'b1; b1.en = 1'b0;
        @(negedge clk);
        check_reg("reg_reset", 1'b0, 1'b0);
        rst = 1'b0;
        b1.in0 = 1'b0; b1.in1 = 1'b1; b1.in2 = 1'b0; b1.in3 = 1'b0;
        b1.sel = 2'b01; b1.en = 1'b1;
        @(negedge clk);
        check_reg("reg_load1", 1'b1, 1'b1);
        @(negedge clk);
        check_reg("reg_load2", 1'b1, 1'b0);
    endtask

    task automatic test_enable_hold();
        b1.en = 1'b0;
        b1.sel = 2'b00;
        #1;
        total++;
        if (b1.out !== 1'b0) begin
            bad++; $display("FAIL hold_out got=%b want=0", b1.out);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_reg("hold", 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_priority();
        b1.sel = 2'b01; b1.in1 = 1'b1;
        rst = 1'b1; b1.en = 1'b1;
        @(negedge clk);
        check_reg("prio_reset", 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_reg("prio_release", 1'b1, 1'b1);
        b1.en = 1'b0;
    endtask

    task automatic test_width4();
        logic [3:0] exp_v [4] = '{4'hA, 4'h5, 4'hF, 4'h0};
        logic [3:0] prev;
        @(negedge clk);
        prev = b4.out_q;
        total++;
        if (prev !== 4'h0) begin
            bad++; $display("FAIL w4_start got=%h want=0", prev);
        end
        b4.in0 = 4'hA; b4.in1 = 4'h5; b4.in2 = 4'hF; b4.in3 = 4'h0;
        b4.en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            b4.sel = 2'(s);
            #1;
            total++;
            if (b4.out !== exp_v[s]) begin
                bad++; $display("FAIL w4_out sel=%0d got=%h want=%h", s, b4.out, exp_v[s]);
            end
            @(negedge clk);
            total++;
            if (b4.out_q !== exp_v[s]) begin
                bad++; $display("FAIL w4_out_q sel=%0d got=%h want=%h", s, b4.out_q, exp_v[s]);
            end
            total++;
            if (b4.out_chg !== (exp_v[s] != prev)) begin
                bad++; $display("FAIL w4_out_chg sel=%0d got=%b want=%b", s, b4.out_chg, exp_v[s] != prev);
            end
            $display("w4 sel=%0d out=%h out_q=%h out_chg=%b", s, b4.out, b4.out_q, b4.out_chg);
            prev = exp_v[s];
        end
        b4.en = 1'b0;
    endtask

    initial begin
        b1.in0 = 1'b0; b1.in1 = 1'b0; b1.in2 = 1'b0; b1.in3 = 1'b0;
        b1.sel = 2'b00; b1.en = 1'b0;
        b4.in0 = 4'h0; b4.in1 = 4'h0; b4.in2 = 4'h0; b4.in3 = 4'h0;
        b4.sel = 2'b00; b4.en = 1'b0;
        @(negedge clk);
        test_reset();
        test_comb_sweep();
        test_map_slice();
        test_register();
        test_enable_hold();
        test_reset_priority();
        test_width4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
